// File: rtl/sevenseg_pkg.sv
// ============================================================================
// Module      : sevenseg_pkg
// Description : Shared digit constants and helpers for the 7-segment scanner.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sevenseg_pkg;

    localparam int DIGIT_W   = 4;
    localparam int DIGIT_MAX = 9;

    // One enable bit in its "off" state; replicate for the full an bus.
    localparam logic c_AN_OFF = 1'b1;

    function automatic logic digit_valid(input logic [DIGIT_W-1:0] nibble);
        return nibble <= DIGIT_W'(DIGIT_MAX);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sevenseg_prescaler.sv
// ============================================================================
// Module      : sevenseg_prescaler
// Description : Slot-rate prescaler; flags the last cycle of each slot and
//               whether the following cycle lies in the dead-time window.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sevenseg_prescaler #(
    parameter int PRESCALE    = 50000,
    parameter int DEAD_CYCLES = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic slot_tick,
    output logic in_dead
);

    localparam int            CW     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] c_LAST = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] c_DEAD = CW'(DEAD_CYCLES);

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;

    assign slot_tick  = (r_cnt == c_LAST);
    assign w_cnt_next = slot_tick ? '0 : r_cnt + CW'(1);
    // Looks one cycle ahead so the registered enables line up with the count.
    assign in_dead    = (w_cnt_next < c_DEAD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_next;
        end
    end

endmodule

`default_nettype wire

// File: rtl/sevenseg_scan.sv
// ============================================================================
// Module      : sevenseg_scan
// Description : Double-buffered multiplexed digit scanner with dead time.
//               Optional leading-zero blanking: define SEVENSEG_SCAN_LZB_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sevenseg_scan
    import sevenseg_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int PRESCALE    = 50000,
    parameter int DEAD_CYCLES = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          load,
    input  logic [DIGIT_W*NUM_DIGITS-1:0] din,
    output logic [DIGIT_W-1:0]            a,
    output logic [NUM_DIGITS-1:0]         an,
    output logic                          pend,
    output logic                          frame_done,
    output logic                          err
);

    localparam int            DW         = DIGIT_W * NUM_DIGITS;
    localparam int            IW         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IW-1:0] c_LAST_IDX = IW'(NUM_DIGITS - 1);

    function automatic logic [DIGIT_W-1:0] nib(input logic [DW-1:0] v, input logic [IW-1:0] i);
        return v[int'(i)*DIGIT_W +: DIGIT_W];
    endfunction

    function automatic logic any_invalid(input logic [DW-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (!digit_valid(v[k*DIGIT_W +: DIGIT_W])) bad = 1'b1;
        end
        return bad;
    endfunction

    logic            slot_tick;
    logic            in_dead;
    logic [IW-1:0]   r_idx;
    logic [DW-1:0]   r_active;
    logic [DW-1:0]   r_shadow;
    logic            w_last_idx;
    logic            w_boundary;
    logic            w_commit;
    logic [IW-1:0]   w_idx_next;
    logic [DW-1:0]   w_active_next;
    logic            w_blank;
    logic [NUM_DIGITS-1:0] w_an_next;

    sevenseg_prescaler #(
        .PRESCALE    (PRESCALE),
        .DEAD_CYCLES (DEAD_CYCLES)
    ) u_prescaler (
        .clk       (clk),
        .rst_n     (rst_n),
        .slot_tick (slot_tick),
        .in_dead   (in_dead)
    );

    assign w_last_idx    = (r_idx == c_LAST_IDX);
    assign w_boundary    = slot_tick && w_last_idx;
    assign w_commit      = w_boundary && (load || pend);
    assign w_idx_next    = slot_tick ? (w_last_idx ? '0 : r_idx + IW'(1)) : r_idx;
    // A load landing on the boundary bypasses the shadow and wins over it.
    assign w_active_next = !w_boundary ? r_active :
                           load        ? din      :
                           pend        ? r_shadow : r_active;

`ifdef SEVENSEG_SCAN_LZB_EN
    function automatic logic [NUM_DIGITS-1:0] lzb_mask(input logic [DW-1:0] v);
        logic [NUM_DIGITS-1:0] m;
        logic                  upper_zero;
        m          = '0;
        upper_zero = 1'b1;
        for (int k = NUM_DIGITS - 1; k > 0; k--) begin
            upper_zero = upper_zero && (v[k*DIGIT_W +: DIGIT_W] == '0);
            m[k]       = upper_zero;
        end
        return m;
    endfunction

    logic [NUM_DIGITS-1:0] r_mask;
    logic [NUM_DIGITS-1:0] w_mask_next;

    assign w_mask_next = w_commit ? lzb_mask(w_active_next) : r_mask;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mask <= lzb_mask('0);
        end else begin
            r_mask <= w_mask_next;
        end
    end
`endif

    always_comb begin
        w_blank = !digit_valid(nib(w_active_next, w_idx_next));
`ifdef SEVENSEG_SCAN_LZB_EN
        w_blank = w_blank || w_mask_next[w_idx_next];
`endif
        w_an_next = {NUM_DIGITS{c_AN_OFF}};
        if (!in_dead && !w_blank) begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
                if (w_idx_next == IW'(k)) w_an_next[k] = ~c_AN_OFF;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx      <= '0;
            r_active   <= '0;
            r_shadow   <= '0;
            pend       <= 1'b0;
            a          <= '0;
            an         <= {NUM_DIGITS{c_AN_OFF}};
            frame_done <= 1'b0;
            err        <= 1'b0;
        end else begin
            r_idx      <= w_idx_next;
            a          <= nib(w_active_next, w_idx_next);
            an         <= w_an_next;
            frame_done <= w_boundary;
            if (w_commit) begin
                r_active <= w_active_next;
                err      <= any_invalid(w_active_next);
            end
            if (w_boundary) begin
                pend <= 1'b0;
            end else if (load) begin
                r_shadow <= din;
                pend     <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sevenseg_scan.sv
// ============================================================================
// Module      : tb_sevenseg_scan
// Description : Self-checking bench for sevenseg_scan (4 digits, 8-cycle slots).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sevenseg_scan;

    localparam int ND = 4;
    localparam int PS = 8;
    localparam int DC = 2;
    localparam int FRAME = ND * PS;

    logic        clk;
    logic        rst_n;
    logic        load;
    logic [15:0] din;
    logic [3:0]  a;
    logic [3:0]  an;
    logic        pend;
    logic        frame_done;
    logic        err;

    sevenseg_scan #(
        .NUM_DIGITS  (ND),
        .PRESCALE    (PS),
        .DEAD_CYCLES (DC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .din        (din),
        .a          (a),
        .an         (an),
        .pend       (pend),
        .frame_done (frame_done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state: cycle count since reset release plus the buffered values.
    int          cyc;
    logic [15:0] m_active;
    logic [15:0] m_shadow;
    logic        m_pend;
    logic        m_err;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    endtask

    function automatic int digit_of(input logic [15:0] v, input int k);
        return (int'(v) >> (4 * k)) & 15;
    endfunction

    function automatic logic has_invalid(input logic [15:0] v);
        for (int k = 0; k < ND; k++) if (digit_of(v, k) > 9) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [3:0] exp_an(input int c);
        int slot_pos = c % PS;
        int k        = (c / PS) % ND;
        if (slot_pos < DC || digit_of(m_active, k) > 9) return 4'hF;
`ifdef SEVENSEG_SCAN_LZB_EN
        if (k > 0 && (int'(m_active) >> (4 * k)) == 0) return 4'hF;
`endif
        return 4'hF & ~(4'(1) << k);
    endfunction

    task automatic check_all();
        chk("a",          {12'h0, a},          16'(digit_of(m_active, (cyc / PS) % ND)));
        chk("an",         {12'h0, an},         {12'h0, exp_an(cyc)});
        chk("pend",       {15'h0, pend},       {15'h0, m_pend});
        chk("frame_done", {15'h0, frame_done}, {15'h0, (cyc > 0) && (cyc % FRAME == 0)});
        chk("err",        {15'h0, err},        {15'h0, m_err});
    endtask

    task automatic model_reset();
        cyc = 0; m_active = '0; m_shadow = '0; m_pend = 1'b0; m_err = 1'b0;
    endtask

    // One clock: drive inputs, advance the reference model, sample after the edge.
    task automatic step(input logic l, input logic [15:0] d);
        logic boundary;
        load = l;
        din  = d;
        boundary = (cyc % FRAME == FRAME - 1);
        if (l && boundary) begin
            m_active = d; m_pend = 1'b0; m_err = has_invalid(d);
        end else if (l) begin
            m_shadow = d; m_pend = 1'b1;
        end else if (boundary && m_pend) begin
            m_active = m_shadow; m_pend = 1'b0; m_err = has_invalid(m_shadow);
        end
        @(posedge clk);
        #1;
        cyc++;
        load = 1'b0;
        check_all();
    endtask

    task automatic goto_phase(input int p);
        for (int n = 0; n < FRAME && (cyc % FRAME) != p; n++) step(1'b0, 16'h0);
    endtask

    typedef struct {
        logic [15:0] din;
        int          phase;
        logic        exp_pend;
        logic        exp_err;
        logic [3:0]  exp_a1;
        logic [3:0]  exp_an1;
    } vec_t;

    vec_t vecs[6];
    logic [3:0] seq_exp[4];

    initial begin
        logic crossed;
        int   n;
        logic [15:0] rd;

        vecs[0] = '{16'h1234,  9, 1'b1, 1'b0, 4'h3, 4'b1101};
        vecs[1] = '{16'h12A4,  5, 1'b1, 1'b1, 4'hA, 4'b1111};
`ifdef SEVENSEG_SCAN_LZB_EN
        vecs[2] = '{16'h0009, 20, 1'b1, 1'b0, 4'h0, 4'b1111};
`else
        vecs[2] = '{16'h0009, 20, 1'b1, 1'b0, 4'h0, 4'b1101};
`endif
        vecs[3] = '{16'h4321, 31, 1'b0, 1'b0, 4'h2, 4'b1101};
        vecs[4] = '{16'h9999,  0, 1'b1, 1'b0, 4'h9, 4'b1101};
        vecs[5] = '{16'hFFFF, 30, 1'b1, 1'b1, 4'hF, 4'b1111};
        seq_exp = '{4'h8, 4'h7, 4'h6, 4'h5};

        rst_n = 1'b0; load = 1'b0; din = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_an", {12'h0, an}, 16'h000F);
        chk("rst_a", {12'h0, a}, 16'h0);
        chk("rst_pend", {15'h0, pend}, 16'h0);
        rst_n = 1'b1;
        check_all();

        // Idle frames straight out of reset.
        for (int i = 0; i < 2 * FRAME + 2; i++) step(1'b0, 16'h0);

        // Directed single loads at chosen frame phases.
        foreach (vecs[v]) begin
            goto_phase(vecs[v].phase);
            step(1'b1, vecs[v].din);
            chk("vec_pend", {15'h0, pend}, {15'h0, vecs[v].exp_pend});
            crossed = (cyc % FRAME == 0);
            n = 0;
            while (!(crossed && cyc % FRAME == 12) && n < 3 * FRAME) begin
                step(1'b0, 16'h0);
                if (cyc % FRAME == 0) crossed = 1'b1;
                n++;
            end
            chk("vec_reach", 16'(n < 3 * FRAME), 16'h1);
            chk("vec_err", {15'h0, err}, {15'h0, vecs[v].exp_err});
            chk("vec_a1", {12'h0, a}, {12'h0, vecs[v].exp_a1});
            chk("vec_an1", {12'h0, an}, {12'h0, vecs[v].exp_an1});
        end

        // Two loads in one frame: only the last reaches the display.
        goto_phase(4);
        step(1'b1, 16'h1111);
        goto_phase(20);
        step(1'b1, 16'h5678);
        chk("dbl_pend", {15'h0, pend}, 16'h1);
        goto_phase(0);
        for (int s = 0; s < ND; s++) begin
            goto_phase(s * PS + 4);
            chk("dbl_digit", {12'h0, a}, {12'h0, seq_exp[s]});
        end

        // Asynchronous reset in the middle of a lit slot with a pending load.
        goto_phase(31);
        step(1'b1, 16'hA000);
        goto_phase(3);
        step(1'b1, 16'h1111);
        goto_phase(20);
        chk("pre_rst_an", {12'h0, an}, 16'h000B);
        chk("pre_rst_err", {15'h0, err}, 16'h1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_an", {12'h0, an}, 16'h000F);
        chk("arst_a", {12'h0, a}, 16'h0);
        chk("arst_pend", {15'h0, pend}, 16'h0);
        chk("arst_err", {15'h0, err}, 16'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        check_all();
        for (int i = 0; i < FRAME + 8; i++) step(1'b0, 16'h0);

        // Random loads against the reference model.
        for (int i = 0; i < 600; i++) begin
            rd = 16'($urandom);
            if ($urandom_range(0, 1) == 0) begin
                for (int k = 0; k < ND; k++) rd[4*k +: 4] = 4'($urandom_range(0, 9));
            end
            step($urandom_range(0, 11) == 0, rd);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
